decode_issue: RTL
=================

# decode_issue

Instruction decode and operand-issue stage sitting directly upstream of the ALU. It accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 16×32 register file, and presents a registered op/tr/sr triple plus destination index to the ALU. A per-register pending scoreboard stalls instructions whose operands await writeback. An HLT instruction parks the stage until reset.

## Interface
- NREG, 16, number of architectural registers (index width 4)
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- inst_valid  in  1  instruction offered
- inst  in  16  {op[15:12], d[11:8], s[7:4], x[3:0]}; LIL uses imm8 = inst[7:0]
- inst_ready  out  1  instruction accepted this cycle when inst_valid & inst_ready
- wb_en  in  1  writeback strobe from downstream
- wb_addr  in  4  writeback register index
- wb_data  in  32  writeback data
- op  out  4  opcode to ALU
- tr  out  32  target operand, R[d]
- sr  out  32  source operand, R[s] or zero-extended imm8
- dst  out  4  destination index, travels with result
- iss_valid  out  1  op/tr/sr/dst valid this cycle
- halted  out  1  HLT has issued

## Operation
- Opcodes: ADD 0, SUB 1, CMP 2, AND 3, OR 4, XOR 5, NEG 6, NOT 7, SLL 8, SRL 9, SRA A, MOV B, LD C, ST D, LIL E, HLT F.
- Operand select: LIL → sr = {24'b0, imm8}, tr = R[d]; all others → tr = R[d], sr = R[s].
- Writing ops: all except ST and HLT. On issue of a writing op, pending[d] set.
- wb_en: R[wb_addr] ← wb_data, pending[wb_addr] cleared. Same-cycle issue setting and wb clearing the same index: set wins.
- Hazard: reads d (all except HLT) or s (all except LIL, NEG, NOT, HLT) while that register is pending → stall. Writing op whose d is pending → stall (WAW).
- inst_ready = (state == RUN) & ~hazard; combinationally dependent on inst (valid-before-ready permitted; ready may not gate valid).
- FSM: RUN → HALT on acceptance of HLT. HALT is terminal until rst_n; writebacks still update the register file in HALT.
- No backpressure from ALU: an issue slot is consumed every accepted cycle.

## Timing
- Reset (async assert, sync-deassert upstream): all R = 0, pending = 0, op/tr/sr/dst = 0, iss_valid = 0, halted = 0, state RUN.
- Latency: instruction accepted in cycle N → op/tr/sr/dst/iss_valid registered, visible cycle N+1. iss_valid = 0 on any cycle with no acceptance; op/tr/sr/dst hold last value.
- HLT accepted cycle N → iss_valid=1, op=F in N+1; halted=1 and inst_ready=0 from N+1.
- Reset mid-stall or in HALT: all state cleared immediately; pending instructions downstream are not tracked.

## Configuration
- DECODE_BYPASS_EN defined: wb write-through; a same-cycle wb to a read index supplies wb_data to the operand and its pending bit counts as clear → no stall.
- Undefined: operands read only from stored registers; pending cleared at end of wb cycle, so a dependent instruction stalls through the wb cycle and issues the cycle after.

## Structure
- Shared package: opcode constants (ADD…HLT), XLEN, register index width, instruction field slice positions, a writes_dst/reads_s helper function.
- Sub-module regfile16x32: two combinational read ports, one write port, async reset to zero, optional bypass under DECODE_BYPASS_EN.
- Top: scoreboard, hazard logic, 2-state FSM, issue register.

## Test plan
- Reset then ADD d=1 s=2 with R1=5, R2=7 preloaded via wb → next cycle iss_valid=1, op=0, tr=5, sr=7, dst=1; pending[1]=1.
- LIL d=3 imm=0xA5 → sr=0x000000A5, tr=R3; then ADD d=4 s=3 stalls (inst_ready=0) until wb_en addr=3.
- wb_en addr=3 data=0x55 in the same cycle as ADD reading R3: with DECODE_BYPASS_EN issues with sr=0x55 next cycle; without, issues one cycle later with sr=0x55.
- Issue ADD d=5 then, same cycle as wb to R5, issue SUB d=5 → pending[5] stays 1 (set wins); ST d=5 then stalls.
- HLT accepted → op=F, iss_valid=1 one cycle, halted=1, inst_ready=0 permanently; wb to R6=9 still lands; rst_n low → halted=0, all outputs 0, R6=0.
- Back-to-back independent ops (ADD 1,2; XOR 3,4; SRA 5,6) with no pending → inst_ready=1 every cycle, three consecutive iss_valid pulses.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: widths, opcodes, instruction
// field positions and opcode classification helpers.
package decode_issue_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 16;
  localparam int RIDX_W = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_CMP = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NEG = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SRL = 4'h9;
  localparam logic [3:0] OP_SRA = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;
  localparam logic [3:0] OP_LD  = 4'hC;
  localparam logic [3:0] OP_ST  = 4'hD;
  localparam logic [3:0] OP_LIL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int D_MSB   = 11;
  localparam int D_LSB   = 8;
  localparam int S_MSB   = 7;
  localparam int S_LSB   = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  function automatic logic writes_dst(input logic [3:0] op);
    return (op != OP_ST) && (op != OP_HLT);
  endfunction

  function automatic logic reads_d(input logic [3:0] op);
    return op != OP_HLT;
  endfunction

  function automatic logic reads_s(input logic [3:0] op);
    return (op != OP_LIL) && (op != OP_NEG) && (op != OP_NOT) && (op != OP_HLT);
  endfunction

endpackage

// File: rtl/regfile16x32.sv
// 16x32 register file: two combinational read ports, one write port.
// With DECODE_BYPASS_EN defined, a same-cycle write is forwarded to the reads.
module regfile16x32
  import decode_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra_addr,
  input  logic [RIDX_W-1:0] rb_addr,
  output logic [XLEN-1:0]   ra_data,
  output logic [XLEN-1:0]   rb_data,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: the array is reset so that every register reads zero after rst_n,
  // which the architecture relies on; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef DECODE_BYPASS_EN
  assign ra_data = (we && (waddr == ra_addr)) ? wdata : mem_q[ra_addr];
  assign rb_data = (we && (waddr == rb_addr)) ? wdata : mem_q[rb_addr];
`else
  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];
`endif

endmodule

// File: rtl/decode_issue.sv
// Decode and operand-issue stage: pending scoreboard, hazard stall, RUN/HALT FSM
// and registered issue slot. Optional write-through via DECODE_BYPASS_EN.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [15:0]       inst,
  output logic              inst_ready,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [3:0]        op,
  output logic [XLEN-1:0]   tr,
  output logic [XLEN-1:0]   sr,
  output logic [RIDX_W-1:0] dst,
  output logic              iss_valid,
  output logic              halted
);

  logic [3:0]        f_op;
  logic [RIDX_W-1:0] f_d;
  logic [RIDX_W-1:0] f_s;
  logic [7:0]        f_imm;

  assign f_op  = inst[OP_MSB:OP_LSB];
  assign f_d   = inst[D_MSB:D_LSB];
  assign f_s   = inst[S_MSB:S_LSB];
  assign f_imm = inst[IMM_MSB:IMM_LSB];

  logic [XLEN-1:0] rd_d_data;
  logic [XLEN-1:0] rd_s_data;

  regfile16x32 u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (f_d),
    .rb_addr (f_s),
    .ra_data (rd_d_data),
    .rb_data (rd_s_data),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  state_t            state_q;
  logic              halted_q;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   busy;
  logic              hazard;
  logic              accept;

  assign wb_hit = {NREG{wb_en}} & (NREG'(1) << wb_addr);

`ifdef DECODE_BYPASS_EN
  // A register being written this cycle is forwarded, so it no longer blocks.
  assign busy = pending_q & ~wb_hit;
`else
  assign busy = pending_q;
`endif

  assign hazard = (reads_d(f_op)    & busy[f_d]) |
                  (reads_s(f_op)    & busy[f_s]) |
                  (writes_dst(f_op) & busy[f_d]);

  assign inst_ready = (state_q == ST_RUN) & ~hazard;
  assign accept     = inst_valid & inst_ready;

  // Set after clear: an issuing writer re-arms its destination even if a
  // writeback to the same index lands this cycle.
  always_comb begin
    pending_d = pending_q & ~wb_hit;
    if (accept && writes_dst(f_op)) pending_d[f_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept && (f_op == OP_HLT)) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   tr_q, tr_d;
  logic [XLEN-1:0]   sr_q, sr_d;
  logic [RIDX_W-1:0] dst_q, dst_d;
  logic              iss_valid_q, iss_valid_d;

  always_comb begin
    op_d        = op_q;
    tr_d        = tr_q;
    sr_d        = sr_q;
    dst_d       = dst_q;
    iss_valid_d = accept;
    if (accept) begin
      op_d  = f_op;
      tr_d  = rd_d_data;
      sr_d  = (f_op == OP_LIL) ? {{(XLEN-8){1'b0}}, f_imm} : rd_s_data;
      dst_d = f_d;
    end
  end

  // NOTE: state updates use non-blocking assignments only; all next-state
  // arithmetic lives in always_comb so simulation order cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      op_q        <= '0;
      tr_q        <= '0;
      sr_q        <= '0;
      dst_q       <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      op_q        <= op_d;
      tr_q        <= tr_d;
      sr_q        <= sr_d;
      dst_q       <= dst_d;
      iss_valid_q <= iss_valid_d;
    end
  end

  assign op        = op_q;
  assign tr        = tr_q;
  assign sr        = sr_q;
  assign dst       = dst_q;
  assign iss_valid = iss_valid_q;
  assign halted    = halted_q;

endmodule
